// File: rtl/pio_poll_master.sv
// pio_poll_master
//   Avalon-MM initiator that polls an 8-bit read-only PIO responder at a fixed
//   interval. Each poll is a single-cycle read. The data comes back with a
//   fixed latency of one cycle. Any sample that differs from the previous one
//   (and the first sample after reset) is queued in a small FWFT change FIFO.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   enable                  level-sensitive polling enable
//   avm_address/avm_read    read address (constant POLL_ADDR) and one-cycle read strobe
//   avm_readdata            responder data, valid the cycle after avm_read; bits [7:0] used
//   current                 last captured sample
//   change_data/valid/ready FWFT change queue head, non-empty flag, consumer pop
//   overflow/clear_overflow sticky "change dropped on full queue" flag and its clear
//   change_count            detected changes including dropped ones, saturating
module pio_poll_master #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [1:0]  POLL_ADDR   = 2'd0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [7:0]  current,
  output logic [7:0]  change_data,
  output logic        change_valid,
  input  logic        change_ready,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic [15:0] change_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  // Full interval, used after reset and whenever enable is low, so the first
  // read lands POLL_PERIOD edges after enable is first seen high.
  localparam logic [15:0] RELOAD_FULL = 16'(POLL_PERIOD);
  // READ and CAPTURE already consume two cycles of the period.
  localparam logic [15:0] RELOAD_RUN  = 16'(POLL_PERIOD - 3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_strobe;
  logic        cap_strobe;

  // FSM state register and interval counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= RELOAD_FULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          cnt_d = RELOAD_FULL;
        end else if (cnt_q == 16'd0) begin
          state_d = READ;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        cnt_d   = RELOAD_RUN;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = RELOAD_FULL;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    rd_strobe  = 1'b0;
    cap_strobe = 1'b0;
    case (state_q)
      READ:    rd_strobe  = 1'b1;
      CAPTURE: cap_strobe = 1'b1;
      default: ;
    endcase
  end

  // Change detection and change queue
  logic [7:0]       sample;
  logic [7:0]       cur_q;
  logic             first_q;
  logic             ovf_q;
  logic [15:0]      chg_cnt_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fill_q;
  logic             is_change, fifo_empty, fifo_full, pop, push, drop;
  logic             unused_readdata;

  assign sample          = avm_readdata[7:0];
  assign unused_readdata = ^avm_readdata[31:8];

  assign is_change  = cap_strobe && (first_q || (sample != cur_q));
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == DEPTH_C);
  assign pop        = !fifo_empty && change_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push       = is_change && (!fifo_full || pop);
  assign drop       = is_change && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q     <= 8'h00;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      chg_cnt_q <= 16'h0000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      if (cap_strobe) begin
        cur_q   <= sample;
        first_q <= 1'b0;
      end
      if (is_change && (chg_cnt_q != 16'hFFFF)) begin
        chg_cnt_q <= chg_cnt_q + 16'd1;
      end
      // A new drop wins over a simultaneous clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_overflow) begin
        ovf_q <= 1'b0;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + CNT_W'(1);
        2'b01:   fill_q <= fill_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; the head output is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  assign avm_address  = POLL_ADDR;
  assign avm_read     = rd_strobe;
  assign current      = cur_q;
  assign change_valid = !fifo_empty;
  assign change_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow     = ovf_q;
  assign change_count = chg_cnt_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Testbench for pio_poll_master: directed scenarios followed by randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_pio_poll_master;

  localparam int         P    = 8;
  localparam int         D    = 4;
  localparam logic [1:0] ADDR = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'h0;
  logic [7:0]  current;
  logic [7:0]  change_data;
  logic        change_valid;
  logic        change_ready = 1'b0;
  logic        overflow;
  logic        clear_overflow = 1'b0;
  logic [15:0] change_count;
  logic [7:0]  in_port = 8'h00;

  pio_poll_master #(
    .POLL_PERIOD (P),
    .POLL_ADDR   (ADDR),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .current        (current),
    .change_data    (change_data),
    .change_valid   (change_valid),
    .change_ready   (change_ready),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .change_count   (change_count)
  );

  always #5 clk = ~clk;

  // Responder: data valid the cycle after a read, junk otherwise and in the upper bits.
  always @(posedge clk)
    avm_readdata <= avm_read ? (($urandom & 32'hFFFF_FF00) | {24'h0, in_port}) : $urandom;

  // Behavioural model (cycle c = interval after clock edge c)
  logic [7:0] mq[$];
  logic [7:0] m_cur, cap_val;
  logic       m_ovf, m_first;
  int         m_cnt, cyc, next_pulse, lp, cap_edge;
  int         n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_clear();
    mq.delete();
    m_cur      = 8'h00;
    m_cnt      = 0;
    m_ovf      = 1'b0;
    m_first    = 1'b1;
    cap_edge   = -1;
    lp         = -100;
    next_pulse = cyc + 1 + P;
  endfunction

  function automatic void model_edge(input logic en, input logic rdy, input logic clr,
                                     input logic rst, input logic [7:0] din);
    int   t;
    logic pop, push, drop, chg;
    t = cyc;
    if (!rst) begin
      model_clear();
      return;
    end
    pop  = (mq.size() != 0) && rdy;
    push = 1'b0;
    drop = 1'b0;
    if (cap_edge == t) begin
      chg     = m_first || (cap_val != m_cur);
      m_cur   = cap_val;
      m_first = 1'b0;
      if (chg) begin
        if (m_cnt < 65535) m_cnt++;
        push = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < D) mq.push_back(cap_val);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    // Read in cycle t-1: responder latches the port at edge t, DUT captures at t+1.
    if (t - 1 == next_pulse) begin
      cap_val    = din;
      cap_edge   = t + 1;
      lp         = t - 1;
      next_pulse = t - 1 + P;
    end
    // Enable low while waiting restarts a full interval.
    if ((t >= lp + 3) && !en) next_pulse = t + 1 + P;
  endfunction

  task automatic check_outputs();
    chk("avm_read", 32'(avm_read), 32'(cyc == next_pulse));
    chk("avm_address", 32'(avm_address), 32'(ADDR));
    chk("current", 32'(current), 32'(m_cur));
    chk("change_valid", 32'(change_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("change_data", 32'(change_data), 32'(mq[0]));
    else chk("change_data", 32'(change_data), 32'h0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("change_count", 32'(change_count), 32'(m_cnt));
  endtask

  task automatic step(input int n);
    logic en, rdy, clr, rst;
    logic [7:0] din;
    for (int i = 0; i < n; i++) begin
      en  = enable;
      rdy = change_ready;
      clr = clear_overflow;
      rst = reset_n;
      din = in_port;
      @(posedge clk);
      cyc++;
      model_edge(en, rdy, clr, rst, din);
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic count_pulses(input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (avm_read) k++;
    end
  endtask

  // Leaves the bench in the cycle where avm_read is high.
  task automatic wait_read(input int budget);
    int w;
    w = 0;
    while (!avm_read && w < budget) begin
      step(1);
      w++;
    end
    if (!avm_read) chk("wait_read_timeout", 32'(avm_read), 32'h1);
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] popped[$];
    logic [7:0] exp_pop [4];
    int k, n;
    exp_pop = '{8'h5A, 8'h01, 8'h02, 8'h03};
    cyc = 0;
    model_clear();

    // Reset with enable already high and the port at 0x5A
    enable  = 1'b1;
    in_port = 8'h5A;
    step(3);
    chk("rst_avm_read", 32'(avm_read), 32'h0);
    chk("rst_current", 32'(current), 32'h0);
    chk("rst_change_valid", 32'(change_valid), 32'h0);
    chk("rst_change_count", 32'(change_count), 32'h0);
    reset_n = 1'b1;

    // First capture reports a change
    step(30);
    chk("first_valid", 32'(change_valid), 32'h1);
    chk("first_data", 32'(change_data), 32'h5A);
    chk("first_count", 32'(change_count), 32'h1);

    // Steady input: ten polls, no new changes
    count_pulses(10 * P, k);
    chk("hold_pulses", 32'(k), 32'd10);
    chk("hold_count", 32'(change_count), 32'h1);
    chk("hold_current", 32'(current), 32'h5A);

    // Fill and overflow with no consumer
    for (int v = 1; v <= 5; v++) begin
      in_port = 8'(v);
      step(P);
    end
    step(P);
    chk("fill_count", 32'(change_count), 32'd6);
    chk("fill_overflow", 32'(overflow), 32'h1);

    // Drain
    change_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (change_valid) popped.push_back(change_data);
      step(1);
    end
    change_ready = 1'b0;
    chk("drain_n", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("drain_val", 32'(popped[i]), 32'(exp_pop[i]));
    chk("drain_empty", 32'(change_valid), 32'h0);

    // clear_overflow on its own
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("clr_alone", 32'(overflow), 32'h0);

    // Full queue, consumer pops in the push cycle
    for (int v = 8'h10; v <= 8'h13; v++) begin
      in_port = 8'(v);
      step(P);
    end
    in_port = 8'h14;
    wait_read(4 * P);
    step(1);
    change_ready = 1'b1;
    step(1);
    change_ready = 1'b0;
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    chk("fullpop_head", 32'(change_data), 32'h11);

    // Enable low: no reads; raising it restarts a full interval
    enable = 1'b0;
    count_pulses(50, k);
    chk("disabled_pulses", 32'(k), 32'd0);
    enable = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!avm_read && n < 100);
    // n includes the edge that first samples enable high.
    chk("first_pulse_delay", 32'(n - 1), 32'(P));

    // Reset asserted during CAPTURE of a changing value
    in_port = 8'h77;
    step(1);
    async_reset();
    chk("rstcap_valid", 32'(change_valid), 32'h0);
    chk("rstcap_current", 32'(current), 32'h0);
    chk("rstcap_count", 32'(change_count), 32'h0);
    chk("rstcap_overflow", 32'(overflow), 32'h0);
    step(2);
    reset_n = 1'b1;

    // clear_overflow coinciding with a drop
    step(P + 4);
    for (int v = 8'h20; v <= 8'h22; v++) begin
      in_port = 8'(v);
      step(P);
    end
    in_port = 8'h23;
    wait_read(4 * P);
    step(1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("clr_vs_drop", 32'(overflow), 32'h1);
    chk("clr_vs_drop_count", 32'(change_count), 32'd5);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    chk("clr_after_drop", 32'(overflow), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable         = ($urandom_range(0, 19) != 0);
      change_ready   = ($urandom_range(0, 2) == 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        step(2);
        reset_n = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pio_poll_master.md
# pio_poll_master

Avalon-MM initiator that periodically polls an 8-bit read-only PIO responder and reports value changes. It issues single-cycle reads at a programmable interval and captures the returned data at fixed read latency 1. It compares each sample with the previous one and queues changed values in a small first-word-fall-through FIFO for downstream logic. It sits between the HPS-side PIO input register block and fabric logic that needs change events instead of raw level sampling.

## Interface
- POLL_PERIOD, 1000: cycles between successive read pulses; legal range 3..65535.
- POLL_ADDR, 0: 2-bit word address of the PIO data register.
- FIFO_DEPTH, 4: change-queue depth, power of two, 2..16.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  polling enable, level-sensitive.
- avm_address  out  2  read address, constant POLL_ADDR.
- avm_read  out  1  read strobe, one-cycle pulse.
- avm_readdata  in  32  responder data, valid the cycle after avm_read; only [7:0] used.
- current  out  8  last captured sample.
- change_data  out  8  FIFO head value.
- change_valid  out  1  FIFO non-empty.
- change_ready  in  1  consumer pop; pop occurs when change_valid && change_ready.
- overflow  out  1  sticky flag: a change was dropped because the FIFO was full.
- clear_overflow  in  1  clears overflow.
- change_count  out  16  total detected changes, including dropped ones; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, READ, CAPTURE.
- IDLE: the interval counter runs while enable=1 and holds its reload value while enable=0. On expiry, go to READ.
- READ: avm_read=1 for exactly one cycle, then go to CAPTURE.
- CAPTURE: sample avm_readdata[7:0], reload the counter, then go to IDLE.
- A change is detected when the sample differs from current, or when this is the first capture since reset.
  - On a change, push the sample and increment change_count.
  - current is updated on every capture.
- Dropping enable during READ or CAPTURE does not abort; the transaction completes, then the FSM waits in IDLE.
- FIFO behaviour:
  - Push when not full.
  - Push while full and no pop in the same cycle: the sample is dropped and overflow is set.
  - Push and pop in the same cycle while full: both are accepted and overflow is not set.
  - Pop while empty is ignored.
- overflow: clear_overflow clears it. When clear_overflow coincides with a new drop, set wins.
- Reset values: avm_read=0, current=0, change_data=0, change_valid=0, overflow=0, change_count=0, FSM=IDLE, counter loaded, FIFO empty.
- Reset asserted mid-operation aborts immediately to the reset values; no partial push occurs.

## Timing
- With enable held high, avm_read pulses occur exactly POLL_PERIOD cycles apart.
  - The first pulse occurs POLL_PERIOD cycles after the first clock edge with enable=1 following reset.
- avm_read high in cycle N: readdata is sampled at the end of cycle N+1; current, change_valid, change_data and change_count update in cycle N+2.
- change_data is registered FWFT: after a push into an empty FIFO, change_valid and change_data are valid in the same cycle.
- After a pop, the next entry appears in the following cycle.
- overflow rises in cycle N+2 of the dropping poll.
- enable low→high restarts a full POLL_PERIOD interval.
- No outstanding-read tracking: the responder has no waitrequest and fixed latency 1.

## Test plan
- Reset, POLL_PERIOD=8, enable=1, in_port=0x5A:
  - avm_read pulses at exactly 8-cycle spacing with avm_address=POLL_ADDR.
  - First capture gives change_valid=1, change_data=0x5A, change_count=1.
- Input held at 0x5A for 10 polls: no further pushes, change_count stays 1, current=0x5A.
- change_ready=0, in_port sequence 0x01,0x02,0x03,0x04,0x05 (FIFO holding 0x5A at the start):
  - After 0x01..0x03, FIFO holds 0x5A,0x01,0x02,0x03 (full).
  - 0x04 is dropped and overflow=1; 0x05 is also dropped.
  - change_count=6.
  - Draining pops 0x5A,0x01,0x02,0x03, then change_valid=0.
- FIFO full with change_ready=1 in the push cycle: no overflow, new value lands at the tail, occupancy stays 4.
- enable low for 50 cycles: zero avm_read pulses.
  - Raising enable gives the first pulse after 8 cycles.
  - reset_n asserted during CAPTURE: all outputs read as reset values the next cycle, nothing pushed.
- clear_overflow pulsed in the same cycle as a drop: overflow stays 1. Pulsed alone: overflow=0 next cycle.
